// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Four-master bus arbiter, round-robin or fixed priority, with
//               per-grant hold timeout and a one-cycle bus turnaround.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd200,
    parameter bit         RR_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic       gnt_strobe,
    output logic       bus_busy,
    output logic       timeout,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  grant_q;
    logic        strobe_q;
    logic        busy_q;
    logic        timeout_q;
    logic [1:0]  owner_q;
    logic [1:0]  last_owner_q;
    logic [7:0]  cnt_q;

    logic [1:0]  rr_winner;
    logic        rr_found;
    logic [1:0]  rr_idx;
    logic [1:0]  fp_winner;
    logic [1:0]  winner;
    logic        rel_drop;
    logic        rel_to;
    logic        rel_any;

    // Round-robin search starts just above the previous owner and wraps.
    always_comb begin
        rr_winner = 2'd0;
        rr_found  = 1'b0;
        rr_idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            rr_idx = last_owner_q + 2'(i + 1);
            if (!rr_found && req[rr_idx]) begin
                rr_winner = rr_idx;
                rr_found  = 1'b1;
            end
        end
    end

    always_comb begin
        fp_winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                fp_winner = 2'(i);
            end
        end
    end

    assign winner   = RR_EN ? rr_winner : fp_winner;
    assign rel_drop = ~req[owner_q];
    assign rel_to   = (cnt_q == TIMEOUT);
    assign rel_any  = done | rel_drop | rel_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 4'b0000;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            owner_q      <= 2'd3;
            last_owner_q <= 2'd3;
            cnt_q        <= 8'd0;
        end else begin
            strobe_q  <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q  <= S_GRANT;
                        grant_q  <= 4'b0001 << winner;
                        busy_q   <= 1'b1;
                        strobe_q <= 1'b1;
                        owner_q  <= winner;
                        cnt_q    <= 8'd1;
                    end
                end
                S_GRANT, S_HOLD: begin
                    if (rel_any) begin
                        state_q   <= S_RELEASE;
                        grant_q   <= 4'b0000;
                        busy_q    <= 1'b0;
                        // A timeout is only flagged when nothing else ended the grant.
                        timeout_q <= rel_to & ~done & ~rel_drop;
                        cnt_q     <= 8'd0;
                    end else begin
                        state_q <= S_HOLD;
                        cnt_q   <= cnt_q + 8'd1;
                    end
                end
                S_RELEASE: begin
                    state_q      <= S_IDLE;
                    last_owner_q <= owner_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign gnt_strobe = strobe_q;
    assign bus_busy   = busy_q;
    assign timeout    = timeout_q;
    assign owner      = owner_q;

endmodule
`default_nettype wire
